// File: rtl/mips_mc_pkg.sv
// Shared definitions for the multicycle MIPS controller: state encoding,
// opcode constants and the ALUOp codes also used by the ALU.
package mips_mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_IEXEC  = 4'd8,
        S_IWB    = 4'd9,
        S_BRANCH = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    function automatic logic is_legal(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_ORI: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mips_mc_if.sv
// Controller <-> datapath signal bundle. Optional perf counters appear
// only when MIPS_MC_PERF_EN is defined.
interface mips_mc_if;
    logic [5:0] OpCode;
    logic [5:0] Funct;
    logic       MemReady;
    logic       PCWrite;
    logic       PCWriteCond;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegDst;
    logic       Mem2Reg;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] PCSource;
    logic       ExtOp;
    logic [3:0] ALUOp;
    logic       Illegal;
    logic [3:0] State;
`ifdef MIPS_MC_PERF_EN
    logic [31:0] CycleCount;
    logic [31:0] InstrCount;
`endif

    modport master (
        input  OpCode, Funct, MemReady,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               RegDst, Mem2Reg, RegWrite, ALUSrcA, ALUSrcB, PCSource,
               ExtOp, ALUOp, Illegal, State
`ifdef MIPS_MC_PERF_EN
        , output CycleCount, InstrCount
`endif
    );

    modport slave (
        output OpCode, Funct, MemReady,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               RegDst, Mem2Reg, RegWrite, ALUSrcA, ALUSrcB, PCSource,
               ExtOp, ALUOp, Illegal, State
`ifdef MIPS_MC_PERF_EN
        , input CycleCount, InstrCount
`endif
    );
endinterface

// File: rtl/mips_mc_aludec.sv
// R-type function-field decoder: Funct -> ALUOp, unknown codes fall back to ADD.
module mips_mc_aludec
    import mips_mc_pkg::*;
(
    input  logic [5:0] i_funct,
    output logic [3:0] o_aluop
);
    always_comb begin
        case (i_funct)
            6'b100000: o_aluop = ALU_ADD;
            6'b100010: o_aluop = ALU_SUB;
            6'b100100: o_aluop = ALU_AND;
            6'b100101: o_aluop = ALU_OR;
            6'b101010: o_aluop = ALU_SLT;
            default:   o_aluop = ALU_ADD;
        endcase
    end
endmodule

// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS control FSM; outputs decoded from the registered state.
// Optional cycle/instruction counters under MIPS_MC_PERF_EN.
module mips_mc_ctrl
    import mips_mc_pkg::*;
(
    input  logic      CLK,
    input  logic      RST,
    mips_mc_if.master bus
);
    state_t     r_state;
    state_t     w_next;
    logic       r_run;
    logic [3:0] w_rtype_op;

    mips_mc_aludec u_aludec (
        .i_funct (bus.Funct),
        .o_aluop (w_rtype_op)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:  if (bus.MemReady) w_next = S_DECODE;
            S_DECODE: begin
                case (bus.OpCode)
                    OP_RTYPE:       w_next = S_EXEC;
                    OP_LW, OP_SW:   w_next = S_MEMADR;
                    OP_BEQ:         w_next = S_BRANCH;
                    OP_J:           w_next = S_JUMP;
                    OP_ADDI, OP_ORI: w_next = S_IEXEC;
                    default:        w_next = S_FETCH;
                endcase
            end
            S_MEMADR: w_next = (bus.OpCode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (bus.MemReady) w_next = S_MEMWB;
            S_MEMWR:  if (bus.MemReady) w_next = S_FETCH;
            S_EXEC:   w_next = S_ALUWB;
            S_IEXEC:  w_next = S_IWB;
            default:  w_next = S_FETCH;
        endcase
    end

    // r_run stays low through reset and the release edge, so the first
    // live FETCH cycle starts on the first rising edge after RST falls.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_FETCH;
            r_run   <= 1'b0;
        end else begin
            r_run <= 1'b1;
            if (r_run) r_state <= w_next;
        end
    end

    assign bus.State = r_state;

    always_comb begin
        bus.PCWrite     = 1'b0;
        bus.PCWriteCond = 1'b0;
        bus.IorD        = 1'b0;
        bus.MemRead     = 1'b0;
        bus.MemWrite    = 1'b0;
        bus.IRWrite     = 1'b0;
        bus.RegDst      = 1'b0;
        bus.Mem2Reg     = 1'b0;
        bus.RegWrite    = 1'b0;
        bus.ALUSrcA     = 1'b0;
        bus.ALUSrcB     = '0;
        bus.PCSource    = '0;
        bus.ExtOp       = 1'b0;
        bus.ALUOp       = '0;
        bus.Illegal     = 1'b0;
        if (r_run) begin
            case (r_state)
                S_FETCH: begin
                    bus.MemRead = 1'b1;
                    bus.ALUSrcB = 2'd1;
                    bus.ALUOp   = ALU_ADD;
                    bus.IRWrite = bus.MemReady;
                    bus.PCWrite = bus.MemReady;
                end
                S_DECODE: begin
                    bus.ALUSrcB = 2'd3;
                    bus.ALUOp   = ALU_ADD;
                    bus.ExtOp   = 1'b1;
                    bus.Illegal = ~is_legal(bus.OpCode);
                end
                S_MEMADR: begin
                    bus.ALUSrcA = 1'b1;
                    bus.ALUSrcB = 2'd2;
                    bus.ExtOp   = 1'b1;
                    bus.ALUOp   = ALU_ADD;
                end
                S_MEMRD: begin
                    bus.MemRead = 1'b1;
                    bus.IorD    = 1'b1;
                end
                S_MEMWB: begin
                    bus.RegWrite = 1'b1;
                    bus.Mem2Reg  = 1'b1;
                end
                S_MEMWR: begin
                    bus.MemWrite = 1'b1;
                    bus.IorD     = 1'b1;
                end
                S_EXEC: begin
                    bus.ALUSrcA = 1'b1;
                    bus.ALUOp   = w_rtype_op;
                end
                S_ALUWB: begin
                    bus.RegWrite = 1'b1;
                    bus.RegDst   = 1'b1;
                end
                S_IEXEC: begin
                    bus.ALUSrcA = 1'b1;
                    bus.ALUSrcB = 2'd2;
                    bus.ALUOp   = (bus.OpCode == OP_ORI) ? ALU_OR : ALU_ADD;
                    bus.ExtOp   = (bus.OpCode == OP_ADDI);
                end
                S_IWB: bus.RegWrite = 1'b1;
                S_BRANCH: begin
                    bus.ALUSrcA     = 1'b1;
                    bus.ALUOp       = ALU_SUB;
                    bus.PCWriteCond = 1'b1;
                    bus.PCSource    = 2'd1;
                end
                S_JUMP: begin
                    bus.PCWrite  = 1'b1;
                    bus.PCSource = 2'd2;
                end
                default: ;
            endcase
        end
    end

`ifdef MIPS_MC_PERF_EN
    logic [31:0] r_cycles;
    logic [31:0] r_instrs;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cycles <= '0;
            r_instrs <= '0;
        end else if (r_run) begin
            r_cycles <= r_cycles + 32'd1;
            if (r_state == S_FETCH && bus.MemReady) r_instrs <= r_instrs + 32'd1;
        end
    end

    assign bus.CycleCount = r_cycles;
    assign bus.InstrCount = r_instrs;
`endif

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Directed bench for mips_mc_ctrl: expected output vectors are queued as each
// cycle is driven and popped/compared at the following falling edge.
module tb_mips_mc_ctrl;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    logic [23:0] sb[$];

    mips_mc_if bus ();
    mips_mc_ctrl dut (.CLK(CLK), .RST(RST), .bus(bus.master));

    always #5 CLK = ~CLK;

    string names[12] = '{"FETCH", "DECODE", "MEMADR", "MEMRD", "MEMWB", "MEMWR",
                         "EXEC", "ALUWB", "IEXEC", "IWB", "BRANCH", "JUMP"};

    // Packing: State, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
    // RegDst, Mem2Reg, RegWrite, ALUSrcA, ALUSrcB, PCSource, ExtOp, ALUOp, Illegal
    function automatic logic [23:0] observed();
        return {bus.State, bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead,
                bus.MemWrite, bus.IRWrite, bus.RegDst, bus.Mem2Reg, bus.RegWrite,
                bus.ALUSrcA, bus.ALUSrcB, bus.PCSource, bus.ExtOp, bus.ALUOp, bus.Illegal};
    endfunction

    function automatic logic [3:0] funct_op(input logic [5:0] fn);
        if (fn == 6'h20) return 4'b0010;
        if (fn == 6'h22) return 4'b0110;
        if (fn == 6'h24) return 4'b0000;
        if (fn == 6'h25) return 4'b0001;
        if (fn == 6'h2A) return 4'b0111;
        return 4'b0010;
    endfunction

    function automatic logic [23:0] model(input int st, input logic [5:0] op,
                                          input logic [5:0] fn, input logic rdy);
        logic pcw = 0, pcc = 0, iord = 0, mrd = 0, mwr = 0, irw = 0;
        logic rdst = 0, m2r = 0, rw = 0, sa = 0, ext = 0, ill = 0;
        logic [1:0] sb2 = 0, pcs = 0;
        logic [3:0] aop = 0;
        case (st)
            0: begin mrd = 1; sb2 = 1; aop = 4'b0010; irw = rdy; pcw = rdy; end
            1: begin
                sb2 = 3; aop = 4'b0010; ext = 1;
                ill = !(op == 6'h00 || op == 6'h23 || op == 6'h2B || op == 6'h04 ||
                        op == 6'h02 || op == 6'h08 || op == 6'h0D);
            end
            2: begin sa = 1; sb2 = 2; ext = 1; aop = 4'b0010; end
            3: begin mrd = 1; iord = 1; end
            4: begin rw = 1; m2r = 1; end
            5: begin mwr = 1; iord = 1; end
            6: begin sa = 1; aop = funct_op(fn); end
            7: begin rw = 1; rdst = 1; end
            8: begin sa = 1; sb2 = 2; aop = (op == 6'h0D) ? 4'b0001 : 4'b0010; ext = (op == 6'h08); end
            9: rw = 1;
            10: begin sa = 1; aop = 4'b0110; pcc = 1; pcs = 1; end
            11: begin pcw = 1; pcs = 2; end
            default: ;
        endcase
        return {4'(st), pcw, pcc, iord, mrd, mwr, irw, rdst, m2r, rw, sa, sb2, pcs, ext, aop, ill};
    endfunction

    task automatic check(input string tag);
        logic [23:0] exp;
        logic [23:0] obs;
        exp = sb.pop_front();
        obs = observed();
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int st, input logic [5:0] op, input logic [5:0] fn, input logic rdy);
        bus.OpCode   = op;
        bus.Funct    = fn;
        bus.MemReady = rdy;
        sb.push_back(model(st, op, fn, rdy));
        @(negedge CLK);
        check(names[st]);
        @(posedge CLK);
        #1;
    endtask

    task automatic do_instr(input logic [5:0] op, input logic [5:0] fn, input int fw, input int mw);
        int seq[$];
        seq = '{0, 1};
        case (op)
            6'h00: seq = '{0, 1, 6, 7};
            6'h23: seq = '{0, 1, 2, 3, 4};
            6'h2B: seq = '{0, 1, 2, 5};
            6'h04: seq = '{0, 1, 10};
            6'h02: seq = '{0, 1, 11};
            6'h08, 6'h0D: seq = '{0, 1, 8, 9};
            default: ;
        endcase
        foreach (seq[k]) begin
            if (seq[k] == 0 || seq[k] == 3 || seq[k] == 5) begin
                repeat ((seq[k] == 0) ? fw : mw) step(seq[k], op, fn, 1'b0);
                step(seq[k], op, fn, 1'b1);
            end else begin
                step(seq[k], op, fn, 1'($urandom_range(0, 1)));
            end
        end
    endtask

    task automatic reset_cycle();
        RST = 1'b1;
        bus.MemReady = 1'b1;
        #1;
        sb.push_back('0);
        check("RST_ASYNC");
        @(posedge CLK);
        #1;
        sb.push_back('0);
        check("RST_HELD");
        RST = 1'b0;
        #1;
        sb.push_back('0);
        check("RST_RELEASED");
        @(posedge CLK);
        #1;
    endtask

    initial begin
        logic [5:0] fns[10];
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h22, 6'h3F, 6'h20, 6'h25};
        bus.OpCode   = '0;
        bus.Funct    = '0;
        bus.MemReady = 1'b0;

        @(posedge CLK);
        #1;
        reset_cycle();

        foreach (fns[i]) do_instr(6'h00, fns[i], 0, 0);
`ifdef MIPS_MC_PERF_EN
        sb.push_back(model(0, 6'h00, 6'h20, 1'b0));
        bus.MemReady = 1'b0;
        #1;
        n_vec++;
        assert ({bus.CycleCount, bus.InstrCount} === {32'd40, 32'd10}) else begin
            n_err++;
            $error("FAIL PERF: got %0d/%0d, want 40/10", bus.CycleCount, bus.InstrCount);
        end
        void'(sb.pop_front());
`endif

        do_instr(6'h23, 6'h00, 0, 3);
        do_instr(6'h2B, 6'h00, 0, 0);
        do_instr(6'h04, 6'h00, 0, 0);
        do_instr(6'h02, 6'h00, 0, 0);
        do_instr(6'h08, 6'h11, 2, 0);
        do_instr(6'h0D, 6'h11, 1, 0);
        do_instr(6'h3F, 6'h00, 0, 0);
        do_instr(6'h2B, 6'h00, 1, 2);

        // Interrupted load: two MEMRD wait cycles then reset mid-wait.
        step(0, 6'h23, 6'h00, 1'b1);
        step(1, 6'h23, 6'h00, 1'b0);
        step(2, 6'h23, 6'h00, 1'b0);
        step(3, 6'h23, 6'h00, 1'b0);
        step(3, 6'h23, 6'h00, 1'b0);
        reset_cycle();
        do_instr(6'h00, 6'h22, 0, 0);
        do_instr(6'h23, 6'h00, 1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/mips_mc_ctrl.md
# mips_mc_ctrl

Multicycle control FSM sequencing the shared MIPS datapath: one memory port, one ALU, instruction register and PC register, with instructions split into fetch/decode/execute/memory/writeback steps. It replaces the single-cycle combinational decoder. It drives every datapath select and strobe from a registered state and stretches memory steps with a ready handshake. It sits beside the datapath top and takes only opcode, funct and memory-ready as inputs.

## Interface
- No parameters.
- CLK  in  1  single clock; all state updates on rising edge.
- RST  in  1  reset; asynchronous, active-high.
- OpCode  in  6  instr[31:26] from the instruction register.
- Funct  in  6  instr[5:0] from the instruction register.
- MemReady  in  1  memory completes the current read or write this cycle.
- PCWrite  out  1  unconditional PC load.
- PCWriteCond  out  1  PC load qualified by ALU Zero (beq).
- IorD  out  1  memory address select: 0 = PC, 1 = ALU result register.
- MemRead  out  1  memory read strobe.
- MemWrite  out  1  memory write strobe.
- IRWrite  out  1  instruction register load.
- RegDst  out  1  GPR write address select: 0 = rt, 1 = rd.
- Mem2Reg  out  1  GPR write data select: 0 = ALU result register, 1 = memory data register.
- RegWrite  out  1  GPR write enable.
- ALUSrcA  out  1  ALU input A select: 0 = PC, 1 = rs.
- ALUSrcB  out  2  ALU input B select: 0 = rt, 1 = constant 4, 2 = extended immediate, 3 = extended immediate << 2.
- PCSource  out  2  next-PC select: 0 = ALU, 1 = ALU result register, 2 = jump target.
- ExtOp  out  1  extender mode: 1 = sign, 0 = zero.
- ALUOp  out  4  ALU operation code.
- Illegal  out  1  one-cycle pulse in DECODE when the opcode is unsupported.
- State  out  4  current state, for debug.

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, IEXEC, IWB, BRANCH, JUMP.
- Outputs are Moore-decoded from State. The exceptions are ALUOp in EXEC (decoded from Funct) and the FETCH strobes (gated by MemReady). Any strobe not listed for a state is 0.
- FETCH:
  - MemRead=1, IorD=0.
  - ALUSrcA=0, ALUSrcB=1, ALUOp=ADD, PCSource=0.
  - IRWrite and PCWrite = MemReady.
  - Stay in FETCH while MemReady=0. Go to DECODE when MemReady=1.
- DECODE:
  - ALUSrcA=0, ALUSrcB=3, ALUOp=ADD, ExtOp=1 (branch target).
  - Next state by OpCode: 000000 → EXEC; 100011 (lw) or 101011 (sw) → MEMADR; 000100 (beq) → BRANCH; 000010 (j) → JUMP; 001000 (addi) or 001101 (ori) → IEXEC.
  - Any other opcode: Illegal=1, go to FETCH.
- MEMADR: ALUSrcA=1, ALUSrcB=2, ExtOp=1, ALUOp=ADD. Go to MEMRD for lw, MEMWR for sw.
- MEMRD: MemRead=1, IorD=1. Hold until MemReady=1, then go to MEMWB.
- MEMWB: RegWrite=1, RegDst=0, Mem2Reg=1. Go to FETCH.
- MEMWR: MemWrite=1, IorD=1. Hold until MemReady=1, then go to FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=0, ALUOp=aludec(Funct). Go to ALUWB.
- ALUWB: RegWrite=1, RegDst=1, Mem2Reg=0. Go to FETCH.
- IEXEC: ALUSrcA=1, ALUSrcB=2, ALUOp=ADD for addi or OR for ori. ExtOp=1 for addi, 0 for ori. Go to IWB.
- IWB: RegWrite=1, RegDst=0, Mem2Reg=0. Go to FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=0, ALUOp=SUB, PCWriteCond=1, PCSource=1. Go to FETCH.
- JUMP: PCWrite=1, PCSource=2. Go to FETCH.
- Unknown Funct in EXEC: ALUOp=ADD. ALUWB still writes.

## Timing
- Cycle counts with MemReady tied to 1: R-type 4, lw 5, sw 4, beq 3, j 3, addi/ori 4.
- Each cycle MemReady is low in FETCH, MEMRD or MEMWR adds exactly one cycle.
- MemRead and MemWrite stay asserted, and IorD stays stable, for the whole wait.
- RST asserted at any time, including mid-wait: State=FETCH immediately.
- While RST=1, every strobe is 0: PCWrite, PCWriteCond, MemRead, MemWrite, IRWrite, RegWrite, Illegal.
- While RST=1, every select and ALUOp is 0.
- The first FETCH cycle is the first rising edge after RST falls.
- MemReady asserted outside a memory state is ignored.

## Configuration
- MIPS_MC_PERF_EN defined:
  - Adds outputs CycleCount[31:0] and InstrCount[31:0], both reset to 0.
  - CycleCount increments every cycle out of reset.
  - InstrCount increments on each FETCH cycle with MemReady=1.
  - Both wrap from 0xFFFFFFFF to 0.
- MIPS_MC_PERF_EN undefined: neither the ports nor the counters exist.

## Structure
- Package mips_mc_pkg holds:
  - the state encoding, State values 0–11 in the listed order;
  - opcode constants;
  - ALUOp constants, shared with the ALU: ADD=0010, SUB=0110, AND=0000, OR=0001, SLT=0111.
- Sub-module mips_mc_aludec: combinational Funct → ALUOp.
  - 100000 → ADD, 100010 → SUB, 100100 → AND, 100101 → OR, 101010 → SLT.
  - Any other Funct → ADD.

## Test plan
- Reset mid-MEMRD wait (RST pulsed while State=MEMRD) → State=FETCH the same cycle, all strobes 0; fetch resumes on the first edge after release.
- OpCode=000000, Funct=100010, MemReady=1 → State sequence FETCH, DECODE, EXEC, ALUWB, FETCH; ALUOp=0110 in EXEC; RegWrite=1 and RegDst=1 only in ALUWB.
- lw with MemReady low for 3 cycles in MEMRD → 8-cycle instruction; MemRead=1 and IorD=1 on all 4 MEMRD cycles; RegWrite and Mem2Reg = 1 in MEMWB.
- sw, beq and j back-to-back → 4, 3 and 3 cycles; MemWrite only in MEMWR; PCWriteCond only in BRANCH; PCWrite with PCSource=2 in JUMP.
- OpCode=111111 → Illegal=1 for one cycle in DECODE; next state FETCH; no RegWrite and no MemWrite.
- With MIPS_MC_PERF_EN defined, 10 R-type instructions after reset → InstrCount=10, CycleCount=40.
